// File: rtl/sdram_wr_feeder.sv
// Write-side feeder for the SDRAM burst engine: buffers user words and issues row-safe bursts.
// Optional underflow/burst counters are enabled with SDRAM_WR_FEEDER_UNDERFLOW_CHK_EN.
module sdram_wr_feeder #(
  parameter int          DEPTH     = 1024,
  parameter int          BURST_LEN = 256,
  parameter logic [23:0] ADDR_MIN  = 24'h000000,
  parameter logic [23:0] ADDR_MAX  = 24'hFFFFFF
) (
  input  logic        wr_clk,
  input  logic        wr_rst_n,
  input  logic        init_end,
  input  logic        usr_wr_valid,
  input  logic [15:0] usr_wr_data,
  output logic        usr_wr_ready,
  input  logic        flush,
  input  logic        addr_rst,
  input  logic        wr_ack,
  input  logic        wr_end,
  output logic        wr_en,
  output logic [23:0] wr_addr,
  output logic [9:0]  wr_bst_len,
  output logic [15:0] wr_data,
  output logic [10:0] fifo_level,
  output logic [1:0]  o_dbg_state
`ifdef SDRAM_WR_FEEDER_UNDERFLOW_CHK_EN
  ,
  output logic        wr_underflow,
  output logic [15:0] burst_cnt
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [10:0] DEPTH_L = 11'(DEPTH);
  localparam logic [9:0]  BL_L    = 10'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

  state_t          r_state;
  logic [15:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [10:0]     r_level;
  logic            r_flush_pend;
  logic            r_addr_rst_pend;
  logic            r_wr_en;
  logic [23:0]     r_wr_addr;
  logic [9:0]      r_bst_len;

  logic            w_push;
  logic            w_pop;
  logic [23:0]     w_addr_eff;
  logic [9:0]      w_room;
  logic [9:0]      w_thresh;
  logic [9:0]      w_len;
  logic            w_go;
  logic [24:0]     w_sum;

  // Handshakes: a word moves in when usr_wr_valid && usr_wr_ready at the clock edge;
  // the engine takes the head word on any edge where wr_ack is high and the FIFO is non-empty.
  assign usr_wr_ready = (r_level < DEPTH_L);
  assign w_push       = usr_wr_valid && usr_wr_ready;
  assign w_pop        = wr_ack && (r_level != 11'd0);
  assign wr_data      = (r_level != 11'd0) ? r_mem[r_rd_ptr] : 16'h0000;
  assign fifo_level   = r_level;

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_bst_len   = r_bst_len;
  assign o_dbg_state  = r_state;

  // A pending address restart is folded in before sizing the next burst.
  assign w_addr_eff = r_addr_rst_pend ? ADDR_MIN : r_wr_addr;
  assign w_room     = 10'd512 - {1'b0, w_addr_eff[8:0]};
  assign w_thresh   = (BL_L < w_room) ? BL_L : w_room;
  assign w_len      = ({1'b0, w_thresh} < r_level) ? w_thresh : r_level[9:0];
  assign w_go       = init_end && ((r_level >= {1'b0, w_thresh}) ||
                                   (r_flush_pend && (r_level != 11'd0)));
  assign w_sum      = {1'b0, r_wr_addr} + {15'd0, r_bst_len};

  always_ff @(posedge wr_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= usr_wr_data;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 11'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 11'd1;
        2'b01:   r_level <= r_level - 11'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_state         <= S_IDLE;
      r_flush_pend    <= 1'b0;
      r_addr_rst_pend <= 1'b0;
      r_wr_en         <= 1'b0;
      r_wr_addr       <= ADDR_MIN;
      r_bst_len       <= 10'd0;
    end else begin
      if (flush)
        r_flush_pend <= 1'b1;
      else if (r_state == S_IDLE && r_level == 11'd0)
        r_flush_pend <= 1'b0;

      if (addr_rst) r_addr_rst_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_addr_rst_pend) begin
            r_wr_addr <= ADDR_MIN;
            if (!addr_rst) r_addr_rst_pend <= 1'b0;
          end
          if (w_go) begin
            r_bst_len <= w_len;
            r_wr_en   <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (wr_ack) begin
            r_wr_en <= 1'b0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (wr_end) begin
            r_wr_addr <= (w_sum > {1'b0, ADDR_MAX}) ? ADDR_MIN : w_sum[23:0];
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SDRAM_WR_FEEDER_UNDERFLOW_CHK_EN
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_underflow <= 1'b0;
      burst_cnt    <= 16'd0;
    end else begin
      if (wr_ack && r_level == 11'd0) wr_underflow <= 1'b1;
      if (r_state == S_BUSY && wr_end) burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_wr_feeder.sv
// Self-checking bench for sdram_wr_feeder: random data and ack gaps against a burst-level model.
module tb_sdram_wr_feeder;

  localparam int          BL    = 256;
  localparam logic [23:0] A_MIN = 24'h000000;
  localparam logic [23:0] A_MAX = 24'h0003FF;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n;
  logic        init_end;
  logic        usr_wr_valid;
  logic [15:0] usr_wr_data;
  logic        usr_wr_ready;
  logic        flush;
  logic        addr_rst;
  logic        wr_ack;
  logic        wr_end;
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [9:0]  wr_bst_len;
  logic [15:0] wr_data;
  logic [10:0] fifo_level;
  logic [1:0]  dbg_state;
`ifdef SDRAM_WR_FEEDER_UNDERFLOW_CHK_EN
  logic        wr_underflow;
  logic [15:0] burst_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [23:0] m_addr;
  bit          m_rst_pend;

  sdram_wr_feeder #(
    .DEPTH(1024), .BURST_LEN(BL), .ADDR_MIN(A_MIN), .ADDR_MAX(A_MAX)
  ) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .init_end(init_end),
    .usr_wr_valid(usr_wr_valid), .usr_wr_data(usr_wr_data), .usr_wr_ready(usr_wr_ready),
    .flush(flush), .addr_rst(addr_rst), .wr_ack(wr_ack), .wr_end(wr_end),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bst_len(wr_bst_len), .wr_data(wr_data),
    .fifo_level(fifo_level), .o_dbg_state(dbg_state)
`ifdef SDRAM_WR_FEEDER_UNDERFLOW_CHK_EN
    , .wr_underflow(wr_underflow), .burst_cnt(burst_cnt)
`endif
  );

  // clock / reset
  always #5 wr_clk = ~wr_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    wr_rst_n = 1'b0; init_end = 1'b0; usr_wr_valid = 1'b0; usr_wr_data = 16'h0;
    flush = 1'b0; addr_rst = 1'b0; wr_ack = 1'b0; wr_end = 1'b0;
    repeat (3) @(posedge wr_clk);
    #1 wr_rst_n = 1'b1;
    exp_q.delete();
    m_addr = A_MIN;
    m_rst_pend = 1'b0;
  endtask

  // reference model: burst sizing and address advance
  function automatic logic [9:0] exp_len(input logic [23:0] a, input int queued, input bit flushing);
    int room, t;
    room = 512 - int'(a % 24'd512);
    t = (BL < room) ? BL : room;
    if (flushing && queued < t) t = queued;
    return 10'(t);
  endfunction

  function automatic logic [23:0] next_addr(input logic [23:0] a, input logic [9:0] l);
    int s;
    s = int'(a) + int'(l);
    return (s > int'(A_MAX)) ? A_MIN : 24'(s);
  endfunction

  // drivers
  task automatic push_one(input logic [15:0] d);
    int guard = 0;
    if ($urandom_range(0, 3) == 0) begin @(posedge wr_clk); #1; end
    usr_wr_valid = 1'b1;
    usr_wr_data  = d;
    @(negedge wr_clk);
    while (!usr_wr_ready && guard < 5000) begin @(negedge wr_clk); guard++; end
    if (!usr_wr_ready) begin
      errors++; checks++;
      $display("FAIL push_timeout: ready=%0b required=1", usr_wr_ready);
    end else exp_q.push_back(d);
    @(posedge wr_clk); #1;
    usr_wr_valid = 1'b0;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_one(16'($urandom));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge wr_clk); #1;
    flush = 1'b0;
  endtask

  task automatic ack_words(input int n, input string name, input bit rst_mid);
    logic [15:0] e;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge wr_clk); #1; end
      wr_ack = 1'b1;
      if (rst_mid && k == n / 2) addr_rst = 1'b1;
      @(negedge wr_clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
      checks++;
      if (wr_data !== e) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %h required %h", name, k, wr_data, e);
      end
      @(posedge wr_clk); #1;
      wr_ack = 1'b0;
      addr_rst = 1'b0;
    end
  endtask

  task automatic wait_wr_en(input string name, output bit ok);
    int guard = 0;
    @(negedge wr_clk);
    while (!wr_en && guard < 20000) begin @(negedge wr_clk); guard++; end
    ok = wr_en;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL %s_req_timeout: wr_en=%0b required=1", name, wr_en);
    end
  endtask

  // engine model: take one request, ack every word, close with wr_end
  task automatic serve_burst(input string name, input bit flushing, input bit rst_mid);
    logic [23:0] ea;
    logic [9:0]  el;
    bit ok;
    ea = m_rst_pend ? A_MIN : m_addr;
    m_rst_pend = 1'b0;
    el = exp_len(ea, exp_q.size(), flushing);
    wait_wr_en(name, ok);
    if (!ok) return;
    checks++;
    if (wr_addr !== ea) begin errors++; $display("FAIL %s_addr: got %h required %h", name, wr_addr, ea); end
    checks++;
    if (wr_bst_len !== el) begin errors++; $display("FAIL %s_len: got %0d required %0d", name, wr_bst_len, el); end
    @(posedge wr_clk); #1;
    ack_words(int'(el), name, rst_mid);
    if (rst_mid) m_rst_pend = 1'b1;
    @(negedge wr_clk);
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL %s_en_drop: got %0b required 0", name, wr_en); end
    @(posedge wr_clk); #1;
    wr_end = 1'b1;
    @(posedge wr_clk); #1;
    wr_end = 1'b0;
    m_addr = next_addr(ea, el);
    @(negedge wr_clk);
    checks++;
    if (wr_addr !== m_addr) begin errors++; $display("FAIL %s_next_addr: got %h required %h", name, wr_addr, m_addr); end
    checks++;
    if (fifo_level !== 11'(exp_q.size())) begin
      errors++; $display("FAIL %s_level: got %0d required %0d", name, fifo_level, exp_q.size());
    end
    @(posedge wr_clk); #1;
  endtask

  task automatic watch_no_req(input string name, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge wr_clk);
      if (wr_en !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL %s: wr_en rose, required to stay 0", name); end
    @(posedge wr_clk); #1;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    @(negedge wr_clk);
    checks++; if (wr_en !== 1'b0)        begin errors++; $display("FAIL rst_wr_en: got %0b required 0", wr_en); end
    checks++; if (wr_addr !== A_MIN)     begin errors++; $display("FAIL rst_wr_addr: got %h required %h", wr_addr, A_MIN); end
    checks++; if (wr_bst_len !== 10'd0)  begin errors++; $display("FAIL rst_bst_len: got %0d required 0", wr_bst_len); end
    checks++; if (fifo_level !== 11'd0)  begin errors++; $display("FAIL rst_level: got %0d required 0", fifo_level); end
    checks++; if (usr_wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b required 1", usr_wr_ready); end
    checks++; if (wr_data !== 16'h0)     begin errors++; $display("FAIL rst_wr_data: got %h required 0000", wr_data); end
    @(posedge wr_clk); #1;
    ack_words(1, "underflow", 1'b0);
    @(negedge wr_clk);
    checks++; if (fifo_level !== 11'd0)  begin errors++; $display("FAIL underflow_level: got %0d required 0", fifo_level); end
    @(posedge wr_clk); #1;
  endtask

  task automatic test_single_burst();
    do_reset();
    init_end = 1'b1;
    for (int i = 0; i < 256; i++) push_one(16'(i));
    serve_burst("single", 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    do_reset();
    init_end = 1'b1;
    push_rand(100);
    watch_no_req("flush_pre_req", 10);
    pulse_flush();
    serve_burst("flush", 1'b1, 1'b0);
    push_rand(5);
    watch_no_req("flush_cleared", 30);
  endtask

  task automatic test_row_split();
    do_reset();
    init_end = 1'b1;
    push_rand(256);
    serve_burst("row_a", 1'b0, 1'b0);
    push_rand(192);
    pulse_flush();
    serve_burst("row_b", 1'b1, 1'b0);
    push_rand(320);
    serve_burst("row_split1", 1'b0, 1'b0);
    serve_burst("row_split2", 1'b0, 1'b0);
  endtask

  task automatic test_wrap_addr_rst();
    do_reset();
    init_end = 1'b1;
    for (int b = 0; b < 4; b++) begin
      push_rand(256);
      serve_burst("wrap", 1'b0, 1'b0);
    end
    push_rand(256);
    serve_burst("wrap5", 1'b0, 1'b1);
    push_rand(256);
    serve_burst("addr_rst", 1'b0, 1'b0);
  endtask

  task automatic test_full_and_simul();
    logic [15:0] d;
    do_reset();
    push_rand(1024);
    usr_wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      usr_wr_data = 16'($urandom);
      @(negedge wr_clk);
      checks++;
      if (usr_wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b required 0", usr_wr_ready); end
      @(posedge wr_clk); #1;
    end
    usr_wr_valid = 1'b0;
    @(negedge wr_clk);
    checks++;
    if (fifo_level !== 11'd1024) begin errors++; $display("FAIL full_level: got %0d required 1024", fifo_level); end
    @(posedge wr_clk); #1;
    ack_words(524, "drain", 1'b0);
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      usr_wr_valid = 1'b1; usr_wr_data = d; wr_ack = 1'b1;
      @(negedge wr_clk);
      checks++;
      if (wr_data !== exp_q[0]) begin errors++; $display("FAIL simul_data[%0d]: got %h required %h", i, wr_data, exp_q[0]); end
      void'(exp_q.pop_front());
      exp_q.push_back(d);
      @(posedge wr_clk); #1;
    end
    usr_wr_valid = 1'b0; wr_ack = 1'b0;
    @(negedge wr_clk);
    checks++;
    if (fifo_level !== 11'd500) begin errors++; $display("FAIL simul_level: got %0d required 500", fifo_level); end
    @(posedge wr_clk); #1;
    ack_words(500, "residue", 1'b0);
  endtask

  task automatic test_init_gate_async_reset();
    bit ok;
    do_reset();
    push_rand(300);
    watch_no_req("init_gate", 50);
    init_end = 1'b1;
    serve_burst("init", 1'b0, 1'b0);
    push_rand(212);
    wait_wr_en("busy", ok);
    if (ok) begin
      checks++;
      if (wr_addr !== 24'h000100) begin errors++; $display("FAIL busy_addr: got %h required 000100", wr_addr); end
      @(posedge wr_clk); #1;
      ack_words(10, "busy", 1'b0);
      #2 wr_rst_n = 1'b0;
      #1;
      checks++; if (wr_en !== 1'b0)        begin errors++; $display("FAIL arst_wr_en: got %0b required 0", wr_en); end
      checks++; if (wr_addr !== A_MIN)     begin errors++; $display("FAIL arst_wr_addr: got %h required %h", wr_addr, A_MIN); end
      checks++; if (wr_bst_len !== 10'd0)  begin errors++; $display("FAIL arst_bst_len: got %0d required 0", wr_bst_len); end
      checks++; if (fifo_level !== 11'd0)  begin errors++; $display("FAIL arst_level: got %0d required 0", fifo_level); end
      checks++; if (usr_wr_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %0b required 1", usr_wr_ready); end
      checks++; if (wr_data !== 16'h0)     begin errors++; $display("FAIL arst_wr_data: got %h required 0000", wr_data); end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_flush();
    test_row_split();
    test_wrap_addr_rst();
    test_full_and_simul();
    test_init_gate_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
